// File: rtl/trap_controller.sv
// Trap/privilege arbiter: interrupts, exceptions, MRET and WFI at instruction boundaries.
// Optional WFI sleep state enabled by defining TRAP_CTRL_WFI_EN.
module trap_controller #(
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irqMask,
    input  logic               irqEnable,
    input  logic               instrValid,
    input  logic               exceptionReq,
    input  logic [3:0]         exceptionCode,
    input  logic               mretReq,
    input  logic               wfiReq,
    input  logic               trapAck,
    output logic               trapTake,
    output logic               mretTake,
    output logic [31:0]        trapCause,
    output logic [1:0]         privilegeLevel,
    output logic [1:0]         prevPrivilege,
    output logic [NUM_IRQ-1:0] irqPending,
    output logic               stall
);

    typedef enum logic [2:0] {
        S_RUN,
        S_TRAP,
        S_WAIT_ACK,
        S_RET
`ifdef TRAP_CTRL_WFI_EN
        , S_SLEEP
`endif
    } state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pend;
    logic               r_trap_take;
    logic               r_mret_take;
    logic [31:0]        r_cause;
    logic [1:0]         r_priv;
    logic [1:0]         r_prev;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_live;
    logic [NUM_IRQ-1:0] w_clr;
    logic [4:0]         w_irq_idx;
    logic               w_irq_any;
    logic               w_go;
    logic               w_acc_irq;
    logic               w_acc_exc;
    logic               w_acc_ill;
    logic               w_acc_mret;
    logic               w_acc_wfi;
    logic               w_trap;
    logic [3:0]         w_exc_code;
    logic [31:0]        w_cause;

    assign w_rise = irq & ~r_irq_q;
    assign w_live = r_pend & irqMask &
                    {NUM_IRQ{irqEnable || (r_priv == 2'b00)}};
    assign w_irq_any = |w_live;

    // Scan downwards so the lowest set index is left in w_irq_idx.
    always_comb begin
        w_irq_idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_live[i]) w_irq_idx = 5'(i);
        end
    end

    assign w_go       = (r_state == S_RUN) && instrValid;
    assign w_acc_irq  = w_go && w_irq_any;
    assign w_acc_exc  = w_go && !w_irq_any && exceptionReq;
    assign w_acc_ill  = w_go && !w_irq_any && !exceptionReq &&
                        mretReq && (r_priv == 2'b00);
    assign w_acc_mret = w_go && !w_irq_any && !exceptionReq &&
                        mretReq && (r_priv != 2'b00);
`ifdef TRAP_CTRL_WFI_EN
    assign w_acc_wfi  = w_go && !w_irq_any && !exceptionReq &&
                        !mretReq && wfiReq;
`else
    logic w_unused_wfi;
    assign w_unused_wfi = wfiReq;
    assign w_acc_wfi    = 1'b0;
`endif
    assign w_trap = w_acc_irq || w_acc_exc || w_acc_ill;

    // ECALL cause depends on the privilege it was raised from (8 from U, 11 from M).
    assign w_exc_code = (exceptionCode == 4'd8) ?
                        (4'd8 + {2'b00, r_priv}) : exceptionCode;

    always_comb begin
        w_cause = 32'd2;
        if (w_acc_irq)
            w_cause = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(w_irq_idx)};
        else if (w_acc_exc)
            w_cause = {28'd0, w_exc_code};
    end

    assign w_clr = w_acc_irq ? (NUM_IRQ'(1) << w_irq_idx) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_irq_q     <= '0;
            r_pend      <= '0;
            r_trap_take <= 1'b0;
            r_mret_take <= 1'b0;
            r_cause     <= 32'd0;
            r_priv      <= 2'b11;
            r_prev      <= 2'b00;
        end else begin
            r_irq_q     <= irq;
            r_pend      <= (r_pend & ~w_clr) | w_rise;
            r_trap_take <= 1'b0;
            r_mret_take <= 1'b0;
            unique case (r_state)
                S_RUN: begin
                    if (w_trap) begin
                        r_state     <= S_TRAP;
                        r_trap_take <= 1'b1;
                        r_cause     <= w_cause;
                        r_prev      <= r_priv;
                        r_priv      <= 2'b11;
                    end else if (w_acc_mret) begin
                        r_state     <= S_RET;
                        r_mret_take <= 1'b1;
                        r_priv      <= r_prev;
                        r_prev      <= 2'b00;
                    end
`ifdef TRAP_CTRL_WFI_EN
                    else if (w_acc_wfi) begin
                        r_state <= S_SLEEP;
                    end
`endif
                end
                S_TRAP:     r_state <= trapAck ? S_RUN : S_WAIT_ACK;
                S_WAIT_ACK: if (trapAck) r_state <= S_RUN;
                S_RET:      if (trapAck) r_state <= S_RUN;
`ifdef TRAP_CTRL_WFI_EN
                S_SLEEP:    if (|(r_pend & irqMask)) r_state <= S_RUN;
`endif
                default:    r_state <= S_RUN;
            endcase
        end
    end

    assign trapTake       = r_trap_take;
    assign mretTake       = r_mret_take;
    assign trapCause      = r_cause;
    assign privilegeLevel = r_priv;
    assign prevPrivilege  = r_prev;
    assign irqPending     = r_pend;
    assign stall          = (r_state != S_RUN) || w_trap ||
                            w_acc_mret || w_acc_wfi;

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq, irqMask;
    logic        irqEnable, instrValid, exceptionReq;
    logic [3:0]  exceptionCode;
    logic        mretReq, wfiReq, trapAck;
    logic        trapTake, mretTake, stall;
    logic [31:0] trapCause;
    logic [1:0]  priv, prev;
    logic [3:0]  pend;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trap_controller #(.NUM_IRQ(4), .IRQ_CAUSE_BASE(16)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .irq           (irq),
        .irqMask       (irqMask),
        .irqEnable     (irqEnable),
        .instrValid    (instrValid),
        .exceptionReq  (exceptionReq),
        .exceptionCode (exceptionCode),
        .mretReq       (mretReq),
        .wfiReq        (wfiReq),
        .trapAck       (trapAck),
        .trapTake      (trapTake),
        .mretTake      (mretTake),
        .trapCause     (trapCause),
        .privilegeLevel(priv),
        .prevPrivilege (prev),
        .irqPending    (pend),
        .stall         (stall)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instrValid   = 1'b0;
        exceptionReq = 1'b0;
        mretReq      = 1'b0;
        wfiReq       = 1'b0;
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        irq = 4'b0; irqMask = 4'b0; irqEnable = 1'b0;
        exceptionCode = 4'd0; trapAck = 1'b0;
        idle_inputs();
        tick(); tick();
        chk("rst_priv", 32'(priv), 32'h3);
        chk("rst_prev", 32'(prev), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_take", 32'(trapTake), 32'h0);
        chk("rst_cause", trapCause, 32'h0);
        rst_n = 1'b1;
        tick();

        // MRET from M with MPP=U drops to U
        instrValid = 1'b1; mretReq = 1'b1;
        #1 chk("mret_stall_comb", 32'(stall), 32'h1);
        tick();
        idle_inputs();
        chk("mret_take", 32'(mretTake), 32'h1);
        chk("mret_priv", 32'(priv), 32'h0);
        chk("mret_stall", 32'(stall), 32'h1);
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        chk("mret_done_stall", 32'(stall), 32'h0);
        chk("mret_done_take", 32'(mretTake), 32'h0);

        // ECALL from U
        instrValid = 1'b1; exceptionReq = 1'b1; exceptionCode = 4'd8;
        tick();
        idle_inputs();
        chk("ecallU_take", 32'(trapTake), 32'h1);
        chk("ecallU_cause", trapCause, 32'h8);
        chk("ecallU_priv", 32'(priv), 32'h3);
        chk("ecallU_prev", 32'(prev), 32'h0);
        tick();
        chk("ecallU_pulse1", 32'(trapTake), 32'h0);
        chk("ecallU_wait_stall", 32'(stall), 32'h1);
        tick(); tick();
        trapAck = 1'b1;
        #1 chk("ecallU_ack_stall", 32'(stall), 32'h1);
        tick();
        trapAck = 1'b0;
        chk("ecallU_run_stall", 32'(stall), 32'h0);
        chk("ecallU_cause_held", trapCause, 32'h8);

        // MRET to U, then MRET in U is illegal
        instrValid = 1'b1; mretReq = 1'b1;
        tick();
        chk("mret2_take", 32'(mretTake), 32'h1);
        chk("mret2_priv", 32'(priv), 32'h0);
        instrValid = 1'b0; mretReq = 1'b0;
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        instrValid = 1'b1; mretReq = 1'b1;
        tick();
        idle_inputs();
        chk("ill_take", 32'(trapTake), 32'h1);
        chk("ill_cause", trapCause, 32'h2);
        chk("ill_priv", 32'(priv), 32'h3);
        chk("ill_mret", 32'(mretTake), 32'h0);
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;

        // Two IRQs rise together; lowest wins over a concurrent exception
        irqMask = 4'b1111; irqEnable = 1'b1; irq = 4'b0110;
        tick();
        chk("irq_pend_set", 32'(pend), 32'h6);
        instrValid = 1'b1; exceptionReq = 1'b1; exceptionCode = 4'd2;
        tick();
        idle_inputs();
        chk("irq1_take", 32'(trapTake), 32'h1);
        chk("irq1_cause", trapCause, 32'h8000_0011);
        chk("irq1_pend", 32'(pend), 32'h4);
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        chk("irq1_run", 32'(stall), 32'h0);

        // irq2 next; ack already high during the TRAP cycle
        instrValid = 1'b1;
        tick();
        idle_inputs();
        chk("irq2_cause", trapCause, 32'h8000_0012);
        chk("irq2_pend", 32'(pend), 32'h0);
        trapAck = 1'b1;
        tick();
        trapAck = 1'b0;
        chk("irq2_fast_ack", 32'(stall), 32'h0);
        irq = 4'b0000;
        tick();

        // ECALL from M gives cause 11, then reset during WAIT_ACK
        instrValid = 1'b1; exceptionReq = 1'b1; exceptionCode = 4'd8;
        tick();
        idle_inputs();
        chk("ecallM_cause", trapCause, 32'hB);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("wrst_cause", trapCause, 32'h0);
        chk("wrst_stall", 32'(stall), 32'h0);
        chk("wrst_priv", 32'(priv), 32'h3);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (trapTake) pulses++;
        end
        chk("wrst_no_pulse", 32'(pulses), 32'h0);

`ifdef TRAP_CTRL_WFI_EN
        irqEnable = 1'b0; irqMask = 4'b0001;
        instrValid = 1'b1; wfiReq = 1'b1;
        #1 chk("wfi_stall_comb", 32'(stall), 32'h1);
        tick();
        idle_inputs();
        chk("wfi_sleep", 32'(stall), 32'h1);
        tick();
        chk("wfi_sleep_hold", 32'(stall), 32'h1);
        irq = 4'b0001;
        tick();
        chk("wfi_pend", 32'(pend), 32'h1);
        chk("wfi_still", 32'(stall), 32'h1);
        tick();
        chk("wfi_wake", 32'(stall), 32'h0);
        chk("wfi_no_take", 32'(trapTake), 32'h0);
        chk("wfi_pend_kept", 32'(pend), 32'h1);
`else
        instrValid = 1'b1; wfiReq = 1'b1;
        #1 chk("wfi_nop_stall", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        chk("wfi_nop_take", 32'(trapTake), 32'h0);
        chk("wfi_nop_run", 32'(stall), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequential trap and privilege unit for the RV32 core; sits between the instruction decoder/controller and the PC/CSR datapath.
- Arbitrates, at each instruction boundary, among synchronous exceptions reported by the decoder, MRET, and NUM_IRQ latched external interrupt lines.
- Tracks the current privilege level (M/U) and the previous privilege level (MPP).
- Drives a trap/return handshake with the datapath, including stalling.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16).
- IRQ_CAUSE_BASE, 16, cause code of irq[0]; irq[i] maps to IRQ_CAUSE_BASE+i.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- irq  input  NUM_IRQ  level interrupt lines; a rising edge sets the pending bit.
- irqMask  input  NUM_IRQ  per-line enable (mie).
- irqEnable  input  1  global enable (mstatus.MIE).
- instrValid  input  1  the decoded instruction is at a boundary this cycle.
- exceptionReq  input  1  the decoder flags an exception for this instruction.
- exceptionCode  input  4  2=illegal, 3=breakpoint, 8=ecall (base).
- mretReq  input  1  the decoder saw MRET.
- wfiReq  input  1  the decoder saw WFI.
- trapAck  input  1  the datapath has loaded the handler/return PC.
- trapTake  output  1  one-cycle pulse: trap entry.
- mretTake  output  1  one-cycle pulse: return taken.
- trapCause  output  32  {isInterrupt, 31-bit code}; held until trapAck.
- privilegeLevel  output  2  2'b11=M, 2'b00=U.
- prevPrivilege  output  2  MPP.
- irqPending  output  NUM_IRQ  latched pending bits.
- stall  output  1  the datapath must hold PC and suppress writes.

Behaviour:

Reset (reset=0 at an edge):
- state=RUN; privilegeLevel=11; prevPrivilege=00; irqPending=0.
- trapTake=0; mretTake=0; trapCause=0.
- Any in-flight trap is abandoned with no pulse.

Pending interrupts:
- irqPending[i] is set on an irq[i] 0->1 edge. A registered irq copy is kept for edge detection.
- irqPending[i] is cleared only when an interrupt trap for line i is accepted.
- If a set and a clear of the same line occur in the same cycle, set wins.

Interrupt eligibility:
- irqLive = irqPending & irqMask, qualified by (irqEnable || privilegeLevel==00).
- The lowest index wins.

States:
- RUN, TRAP, WAIT_ACK, RET, SLEEP (SLEEP only with the optional feature).

RUN, only when instrValid=1, with priority highest first:
- (a) irqLive!=0: accept interrupt; trapCause={1, IRQ_CAUSE_BASE+idx}. The instruction is not executed.
- (b) exceptionReq: trapCause={0, code}. If code==8, the cause is 8+privilegeLevel (8 from U, 11 from M).
- (c) mretReq && privilegeLevel==00: illegal instruction trap, cause 2.
- (d) mretReq in M: go to RET.
- (e) wfiReq: see Optional Feature.
- An accept in (a)-(c) moves to TRAP. At that edge: prevPrivilege<=privilegeLevel and privilegeLevel<=11.

TRAP:
- trapTake=1 for exactly one cycle, then go to WAIT_ACK.
- If trapAck is already 1 in TRAP, go straight to RUN.

WAIT_ACK:
- Hold trapCause until trapAck=1, then go to RUN.

RET:
- mretTake=1 for one cycle.
- At the entry edge: privilegeLevel<=prevPrivilege and prevPrivilege<=00.
- Wait for trapAck, then go to RUN.

stall:
- stall = (state!=RUN) || (RUN && accepting a trap/mret this cycle). The accepting term is combinational.

During TRAP/WAIT_ACK/RET:
- exceptionReq, mretReq and wfiReq are ignored.
- irq edges are still latched.

Latency:
- Request seen at edge N; trapTake is high in cycle N+1.
- The earliest next trap is accepted at the edge after the trapAck cycle.

Optional Feature:
- Macro TRAP_CTRL_WFI_EN.
- Defined:
  - wfiReq in RUN (no higher-priority event) goes to SLEEP; stall=1.
  - SLEEP leaves to RUN when (irqPending & irqMask)!=0, regardless of irqEnable. The wake is reported with no trapTake; the interrupt itself is then taken normally if eligible.
  - reset in SLEEP goes to RUN.
- Undefined:
  - wfiReq is treated as a NOP (no stall); the SLEEP state is absent.

Test Plan:
1. Reset low 2 cycles, then high -> privilegeLevel=11, prevPrivilege=00, stall=0, irqPending=0, trapTake=0.
2. privilegeLevel=00, instrValid=1, exceptionReq=1, exceptionCode=8 -> next cycle trapTake=1, trapCause=0x00000008, privilegeLevel=11, prevPrivilege=00; trapAck after 3 cycles -> stall drops the following cycle.
3. irqMask=4'b1111, irqEnable=1, irq[2] and irq[1] rise in the same cycle; instrValid=1 together with exceptionReq=1 (code 2) -> trapCause=0x80000011 (irq1 wins over irq2 and the exception), irqPending=4'b0100 afterwards.
4. M-mode with prevPrivilege=00, mretReq=1 -> mretTake pulse, privilegeLevel=00; a second mretReq in U -> trapTake with trapCause=0x00000002.
5. In WAIT_ACK, drive reset=0 for one edge -> state RUN, trapTake never pulses again, trapCause=0.
6. With TRAP_CTRL_WFI_EN: wfiReq=1, irqEnable=0 -> stall held high; irq[0] rises with irqMask[0]=1 -> leaves SLEEP next edge, no trapTake, irqPending=4'b0001.
